// File: rtl/slave_spi_pkg.sv
// ============================================================================
// slave_spi_pkg : shared SPI word/mode constants and slave FSM state codes.
// Revision 1.0
// ============================================================================
`default_nettype none

package slave_spi_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int CPOL       = 0;
  localparam int CPHA       = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } slave_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_ff.sv
// ============================================================================
// sync_ff : two-flop synchroniser with a configurable reset value.
// Revision 1.0
// ============================================================================
`default_nettype none

module sync_ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/slave_spi.sv
// ============================================================================
// slave_spi : oversampled SPI slave, one word per frame (multi-word when
//             SLAVE_BURST_EN is defined).
// Revision 1.0
// ============================================================================
`default_nettype none

module slave_spi #(
  parameter int DATA_WIDTH = slave_spi_pkg::DATA_WIDTH,
  parameter int CPOL       = slave_spi_pkg::CPOL,
  parameter int CPHA       = slave_spi_pkg::CPHA
) (
  input  logic                  clk_s,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  ss,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] data_in_slave,
  input  logic                  load,
  output logic [DATA_WIDTH-1:0] data_out_slave,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  busy
);

  import slave_spi_pkg::*;

  localparam int             c_CW             = $clog2(DATA_WIDTH + 1);
  localparam logic [c_CW-1:0] c_CNT_FULL       = c_CW'(DATA_WIDTH);
  localparam bit             c_SAMPLE_ON_RISE = ((CPOL ^ CPHA) == 0);

  logic w_sclk_s, w_ss_s, w_mosi_s;
  logic r_sclk_d, r_ss_d;

  sync_ff #(.RST_VAL(1'b1)) u_sync_ss (
    .clk(clk_s), .rst_n(rst_n), .i_d(ss), .o_q(w_ss_s)
  );
  sync_ff #(.RST_VAL(1'(CPOL))) u_sync_sclk (
    .clk(clk_s), .rst_n(rst_n), .i_d(sclk), .o_q(w_sclk_s)
  );
  sync_ff #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk_s), .rst_n(rst_n), .i_d(mosi), .o_q(w_mosi_s)
  );

  logic w_sclk_rise, w_sclk_fall, w_sample, w_shift, w_ss_fall, w_ss_rise;

  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_sample    = c_SAMPLE_ON_RISE ? w_sclk_rise : w_sclk_fall;
  assign w_shift     = c_SAMPLE_ON_RISE ? w_sclk_fall : w_sclk_rise;
  assign w_ss_fall   = ~w_ss_s & r_ss_d;
  assign w_ss_rise   = w_ss_s & ~r_ss_d;

  slave_state_t             r_state, w_state_next;
  logic [c_CW-1:0]          r_cnt;
  logic [DATA_WIDTH-1:0]    r_rx_sr, r_tx_sr, r_tx_buf, r_data_out;
  logic                     r_valid, r_frame_err, r_busy, r_miso;
  logic [1:0]               r_settle;
  logic                     r_armed;
  logic                     w_start, w_done, w_abort;

  // A frame may only start once ss has been seen high after reset, so a
  // reset released mid-frame never captures the tail of that frame.
  always_ff @(posedge clk_s or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_d <= 1'(CPOL);
      r_ss_d   <= 1'b1;
      r_settle <= 2'd0;
      r_armed  <= 1'b0;
    end else begin
      r_sclk_d <= w_sclk_s;
      r_ss_d   <= w_ss_s;
      if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
      if (r_settle == 2'd3 && r_ss_d) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk_s or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ss_fall && r_armed) begin
          w_state_next = S_SHIFT;
          w_start      = 1'b1;
        end
      end
      S_SHIFT: begin
        if (r_cnt == c_CNT_FULL) begin
          w_done = 1'b1;
`ifdef SLAVE_BURST_EN
          if (w_ss_rise) w_state_next = S_IDLE;
`else
          w_state_next = w_ss_rise ? S_IDLE : S_HOLD;
`endif
        end else if (w_ss_rise) begin
          w_state_next = S_IDLE;
          w_abort      = (r_cnt != '0);
        end
      end
      S_HOLD: begin
        if (w_ss_rise) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_s or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_rx_sr     <= '0;
      r_tx_sr     <= '0;
      r_tx_buf    <= '0;
      r_data_out  <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
      r_miso      <= 1'b0;
    end else begin
      r_valid     <= w_done;
      r_frame_err <= w_abort;
      r_busy      <= (w_state_next != S_IDLE);
      r_miso      <= (r_state == S_SHIFT) & r_tx_sr[DATA_WIDTH-1];
      if (load) r_tx_buf <= data_in_slave;
      if (w_done) r_data_out <= r_rx_sr;

      if (w_start) begin
        r_cnt   <= '0;
        r_rx_sr <= '0;
        r_tx_sr <= r_tx_buf;
      end else if (r_state == S_SHIFT) begin
        if (w_done) begin
          // Reload for the next burst word; invisible when leaving S_SHIFT.
          r_cnt   <= '0;
          r_tx_sr <= r_tx_buf;
        end else begin
          if (w_sample) begin
            r_rx_sr <= {r_rx_sr[DATA_WIDTH-2:0], w_mosi_s};
            r_cnt   <= r_cnt + 1'b1;
          end
          // No shift before the first sample keeps the MSB on miso.
          if (w_shift && r_cnt != '0) r_tx_sr <= {r_tx_sr[DATA_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  assign miso           = r_miso;
  assign data_out_slave = r_data_out;
  assign valid          = r_valid;
  assign frame_err      = r_frame_err;
  assign busy           = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_slave_spi.sv
// ============================================================================
// tb_slave_spi : drives all four SPI modes as a bench-side master and checks
//                the slaves against a word-level model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_slave_spi;

`ifdef SLAVE_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sclk_v;
  logic [3:0] ss_v;
  logic       mosi;
  logic [7:0] data_in;
  logic       load;
  logic [3:0] miso_v, valid_v, ferr_v, busy_v;
  logic [7:0] dout_v [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    slave_spi #(.DATA_WIDTH(8), .CPOL(g / 2), .CPHA(g % 2)) u_dut (
      .clk_s(clk), .rst_n(rst_n), .sclk(sclk_v[g]), .ss(ss_v[g]), .mosi(mosi),
      .miso(miso_v[g]), .data_in_slave(data_in), .load(load),
      .data_out_slave(dout_v[g]), .valid(valid_v[g]), .frame_err(ferr_v[g]),
      .busy(busy_v[g])
    );
  end

  int         n_checks = 0;
  int         n_err    = 0;
  int         active   = -1;
  int         err_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;
  logic [7:0] tx_buf_m;
  logic [7:0] last_data [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    data_in = v;
    load    = 1'b1;
    @(negedge clk);
    load     = 1'b0;
    tx_buf_m = v;
  endtask

  task automatic chk_reset();
    for (int g = 0; g < 4; g++) begin
      chk("rst_miso", miso_v[g], 0);
      chk("rst_dout", dout_v[g], 0);
      chk("rst_valid", valid_v[g], 0);
      chk("rst_ferr", ferr_v[g], 0);
      chk("rst_busy", busy_v[g], 0);
    end
  endtask

  // One frame of nbits bits (MSB of 'bits' first); model predictions are
  // formed before any stimulus is driven.
  task automatic frame(input int m, input int nbits, input logic [15:0] bits,
                       input int h, input int ld_at, input logic [7:0] ld_val,
                       output logic [7:0] c0, output logic [7:0] c1);
    int         cpha, nw;
    bit         err;
    logic [7:0] e0, e1;
    cpha = m % 2;
    nw   = BURST ? nbits / 8 : (nbits >= 8 ? 1 : 0);
    err  = (nbits % 8 != 0) && (BURST || nbits < 8);
    e0   = tx_buf_m;
    e1   = BURST ? tx_buf_m : 8'h00;
    for (int k = 0; k < nw; k++) begin
      exp_q.push_back(k == 0 ? bits[15:8] : bits[7:0]);
      last_data[m] = (k == 0) ? bits[15:8] : bits[7:0];
    end
    err_seen = 0;
    active   = m;
    c0 = 8'h00;
    c1 = 8'h00;
    @(negedge clk);
    ss_v[m] = 1'b0;
    if (cpha == 0) mosi = bits[15];
    wait_cyc(h);
    for (int i = 0; i < nbits; i++) begin
      if (i == ld_at) do_load(ld_val);
      if (cpha == 0) begin
        if (i < 8) c0 = {c0[6:0], miso_v[m]}; else c1 = {c1[6:0], miso_v[m]};
        sclk_v[m] = ~sclk_v[m];
        wait_cyc(h);
        sclk_v[m] = ~sclk_v[m];
        if (i < 15) mosi = bits[14 - i];
        wait_cyc(h);
      end else begin
        sclk_v[m] = ~sclk_v[m];
        mosi = bits[15 - i];
        wait_cyc(h);
        if (i < 8) c0 = {c0[6:0], miso_v[m]}; else c1 = {c1[6:0], miso_v[m]};
        sclk_v[m] = ~sclk_v[m];
        wait_cyc(h);
      end
    end
    chk("busy_in_frame", busy_v[m], 1);
    ss_v[m] = 1'b1;
    mosi    = 1'b0;
    wait_cyc(2 * h + 6);
    chk("valid_count", exp_q.size(), 0);
    exp_q.delete();
    chk("frame_err_count", err_seen, {31'd0, err});
    chk("busy_after", busy_v[m], 0);
    chk("dout_hold", dout_v[m], last_data[m]);
    if (nbits >= 8)  chk("miso_word0", c0, e0);
    if (nbits >= 16) chk("miso_word1", c1, e1);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int g = 0; g < 4; g++) begin
        if (valid_v[g] || ferr_v[g]) chk("pulse_exclusive", valid_v[g] & ferr_v[g], 0);
        if (valid_v[g]) begin
          chk("valid_expected", (g == active && exp_q.size() != 0) ? 1 : 0, 1);
          if (g == active && exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            chk("valid_data", dout_v[g], exp_w);
          end
        end
        if (ferr_v[g]) begin
          chk("ferr_instance", (g == active) ? 1 : 0, 1);
          err_seen++;
        end
      end
    end
  end

  initial begin
    logic [7:0] c0, c1;
    int         nb_tab[7];
    nb_tab = '{8, 8, 16, 3, 12, 0, 5};
    rst_n    = 1'b0;
    ss_v     = 4'b1111;
    sclk_v   = 4'b1100;
    mosi     = 1'b0;
    load     = 1'b0;
    data_in  = 8'h00;
    tx_buf_m = 8'h00;
    for (int g = 0; g < 4; g++) last_data[g] = 8'h00;
    wait_cyc(3);
    chk_reset();
    rst_n = 1'b1;
    wait_cyc(10);

    // Basic exchange in every mode.
    for (int m = 0; m < 4; m++) begin
      do_load(8'h3C);
      frame(m, 8, 16'hA500, 6, -1, 8'h00, c0, c1);
      chk("mode_slave_rx", dout_v[m], 8'hA5);
      chk("mode_master_rx", c0, 8'h3C);
    end

    // Abort after three bits keeps the old word.
    frame(1, 3, 16'hE000, 7, -1, 8'h00, c0, c1);
    chk("abort_hold", dout_v[1], 8'hA5);

    // Load mid-frame only affects the following frame.
    do_load(8'h3C);
    frame(2, 8, 16'h6900, 7, 4, 8'hC3, c0, c1);
    chk("load_mid_cur", c0, 8'h3C);
    frame(2, 8, 16'h9600, 7, -1, 8'h00, c0, c1);
    chk("load_mid_next", c0, 8'hC3);

    // Two words under one ss low.
    for (int m = 0; m < 4; m += 3) begin
      do_load(8'h77);
      frame(m, 16, 16'h1234, 7, -1, 8'h00, c0, c1);
      chk("burst_last", dout_v[m], BURST ? 8'h34 : 8'h12);
      chk("burst_miso2", c1, BURST ? 8'h77 : 8'h00);
    end

    // Randomised frames over all modes.
    for (int m = 0; m < 4; m++) begin
      for (int r = 0; r < 6; r++) begin
        if ($urandom_range(0, 2) == 0) do_load(8'($urandom));
        frame(m, nb_tab[$urandom_range(0, 6)], 16'($urandom), $urandom_range(6, 9),
              -1, 8'h00, c0, c1);
      end
    end

    // Reset mid-frame with ss held low through release.
    active = 0;
    @(negedge clk);
    ss_v[0] = 1'b0;
    mosi    = 1'b1;
    wait_cyc(8);
    repeat (4) begin
      sclk_v[0] = 1'b1; wait_cyc(8);
      sclk_v[0] = 1'b0; wait_cyc(8);
    end
    rst_n    = 1'b0;
    tx_buf_m = 8'h00;
    exp_q.delete();
    for (int g = 0; g < 4; g++) last_data[g] = 8'h00;
    wait_cyc(2);
    chk_reset();
    rst_n = 1'b1;
    repeat (6) begin
      sclk_v[0] = 1'b1; wait_cyc(8);
      chk("post_rst_busy", busy_v[0], 0);
      sclk_v[0] = 1'b0; wait_cyc(8);
      chk("post_rst_miso", miso_v[0], 0);
    end
    chk_reset();
    ss_v[0] = 1'b1;
    wait_cyc(20);
    frame(0, 8, 16'h5A00, 8, -1, 8'h00, c0, c1);
    chk("post_rst_rx", dout_v[0], 8'h5A);
    chk("post_rst_txbuf", c0, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
